fw_header_classifier: RTL and testbench
=======================================

Name: fw_header_classifier

Overview:
- Firewall-side responder to the packet dispatcher's header FIFO: pops one header entry (id, PRT slot tag, 5-tuple) via valid/ready and scans a programmable rule table, one rule per cycle.
- Returns a verdict (id, tag, safe/unsafe) on a valid/ready result channel.
- Safe verdicts feed the dispatcher's send path; unsafe verdicts feed its invalidate path.

Parameters:
- NUM_RULES, 8: rule table depth; must be ≥2.
- TAG_W, 2: PRT slot tag width.
- DEFAULT_SAFE, 0: verdict when no rule matches; 1 = safe, 0 = drop.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hdr_valid  in  1  header entry available
- hdr_ready  out  1  classifier accepts header
- hdr_id  in  1  ethernet port id
- hdr_tag  in  TAG_W  PRT slot tag
- hdr_protocol  in  8  IP protocol
- hdr_srcip  in  32  source IP; carried but not matched
- hdr_dstip  in  32  destination IP
- hdr_srcport  in  16  source port; carried but not matched
- hdr_dstport  in  16  destination port
- rule_wr_en  in  1  rule table write strobe
- rule_wr_idx  in  $clog2(NUM_RULES)  entry index
- rule_wr_data  in  106  {valid[105], safe[104], protocol[103:96], dstip[95:64], dstmask[63:32], port_lo[31:16], port_hi[15:0]}
- res_valid  out  1  verdict available
- res_ready  in  1  dispatcher accepts verdict
- res_id  out  1  echoed hdr_id
- res_tag  out  TAG_W  echoed hdr_tag
- res_safe  out  1  1 = send, 0 = invalidate

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; hdr_ready=1; res_valid=0; res_id=0; res_tag=0; res_safe=0; scan index=0; all rule valid bits=0.
- Header capture: on an edge with hdr_valid & hdr_ready, register all header fields and go to SCAN with idx=0. hdr_ready=1 only in IDLE.
- SCAN, one cycle per rule idx. A rule matches when all of these hold:
  - valid=1
  - protocol==0 (wildcard) or protocol==hdr_protocol
  - (hdr_dstip & dstmask)==(dstip & dstmask)
  - port_lo ≤ hdr_dstport ≤ port_hi, unsigned, inclusive
- Scan results:
  - Match: lowest index wins; latch res_safe=rule.safe and go to RESPOND.
  - No match and idx==NUM_RULES-1: res_safe=DEFAULT_SAFE; go to RESPOND.
  - Otherwise idx+1.
  - Rules with port_lo > port_hi never match.
- RESPOND: res_valid=1 with res_id/res_tag/res_safe stable until an edge with res_valid & res_ready. After that edge: res_valid=0, state=IDLE, hdr_ready=1 next cycle; there is no bypass.
- Latency: accept at edge k, match at index m (or m=NUM_RULES-1 for no match) → res_valid high after edge k+m+1. Minimum header-to-header throughput is m+3 cycles.
- Rule writes:
  - Accepted in any state; table update at the write edge.
  - A rule evaluated in the same cycle as its write uses the old contents.
  - rule_wr_idx ≥ NUM_RULES is ignored.
- Simultaneous events:
  - Write and scan of the same entry: scan sees the old value.
  - hdr_valid in SCAN or RESPOND is held off by hdr_ready=0.
- Reset mid-scan or mid-respond: in-flight header dropped with no verdict; rules cleared.

Optional Feature:
- Macro: FW_CLASSIFIER_STATS_EN.
- Defined:
  - Adds outputs stat_safe_cnt[31:0] and stat_drop_cnt[31:0], reset 0.
  - Each increments by 1 on every res_valid & res_ready handshake according to res_safe.
  - Counters saturate at 32'hFFFF_FFFF.
  - Adds input stat_clr; when 1, both counters go to 0 synchronously. If clear and increment coincide, the result is 0.
- Not defined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Post-reset, empty table, DEFAULT_SAFE=0: header tag=2, id=1 → res_valid after edge k+8 with res_tag=2, res_id=1, res_safe=0.
- Rule 3 = {valid, safe=1, proto=6, dstip=10.0.0.0, mask=255.0.0.0, ports 80..80}; header proto=6, dst 10.1.2.3:80 → res_safe=1 after edge k+4. Same header with dstport 81 → default verdict after edge k+8.
- Rule 1 safe=0 and rule 5 safe=1, both matching with proto wildcard 0 → res_safe=0 at k+2 (lowest index wins).
- Hold res_ready=0 for 5 cycles: res_valid and outputs stay stable and hdr_ready=0. After the handshake, the next header is accepted the cycle after.
- Assert rst during SCAN at idx=2: hdr_ready=1 and res_valid=0 immediately. A re-sent header classifies against the empty table.
- With FW_CLASSIFIER_STATS_EN: 3 safe and 2 drop handshakes → stat_safe_cnt=3, stat_drop_cnt=2. stat_clr coinciding with a handshake → both counters 0.

Source files
------------

// File: rtl/fw_header_classifier.sv
// fw_header_classifier: accepts one header at a time, scans the rule table one entry per cycle
// and returns a safe/drop verdict. Define FW_CLASSIFIER_STATS_EN to add the verdict counters.
//
// state   | meaning
// IDLE    | hdr_ready high, waiting for a header
// SCAN    | evaluating rule idx against the captured header
// RESPOND | verdict held on the result channel until res_ready
module fw_header_classifier #(
  parameter int NUM_RULES    = 8,
  parameter int TAG_W        = 2,
  parameter bit DEFAULT_SAFE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hdr_valid,
  output logic                         hdr_ready,
  input  logic                         hdr_id,
  input  logic [TAG_W-1:0]             hdr_tag,
  input  logic [7:0]                   hdr_protocol,
  input  logic [31:0]                  hdr_srcip,
  input  logic [31:0]                  hdr_dstip,
  input  logic [15:0]                  hdr_srcport,
  input  logic [15:0]                  hdr_dstport,
  input  logic                         rule_wr_en,
  input  logic [$clog2(NUM_RULES)-1:0] rule_wr_idx,
  input  logic [105:0]                 rule_wr_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_id,
  output logic [TAG_W-1:0]             res_tag,
  output logic                         res_safe
`ifdef FW_CLASSIFIER_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [31:0]                  stat_safe_cnt,
  output logic [31:0]                  stat_drop_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_RULES);
  localparam logic [IDX_W:0] NUM_RULES_EXT = (IDX_W+1)'(NUM_RULES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESPOND} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic [7:0]       cap_protocol;
  logic [31:0]      cap_dstip;
  logic [15:0]      cap_dstport;

  logic             rule_valid [NUM_RULES];
  logic [104:0]     rule_data  [NUM_RULES];

  logic             hdr_fire;
  logic             res_fire;
  logic             last_idx;
  logic             wr_ok;
  logic             rule_hit;

  logic [104:0]     cur;
  logic             cur_safe;
  logic [7:0]       cur_protocol;
  logic [31:0]      cur_dstip;
  logic [31:0]      cur_mask;
  logic [15:0]      cur_port_lo;
  logic [15:0]      cur_port_hi;

  // Source address/port travel with the header but take no part in matching.
  logic unused_hdr_fields;
  assign unused_hdr_fields = ^{hdr_srcip, hdr_srcport};

  assign hdr_ready = (state == IDLE);
  assign res_valid = (state == RESPOND);
  assign hdr_fire  = hdr_valid & hdr_ready;
  assign res_fire  = res_valid & res_ready;
  assign last_idx  = (idx == LAST_IDX);
  assign wr_ok     = rule_wr_en && ({1'b0, rule_wr_idx} < NUM_RULES_EXT);

  assign cur          = rule_data[idx];
  assign cur_safe     = cur[104];
  assign cur_protocol = cur[103:96];
  assign cur_dstip    = cur[95:64];
  assign cur_mask     = cur[63:32];
  assign cur_port_lo  = cur[31:16];
  assign cur_port_hi  = cur[15:0];

  // An inverted port range fails the range test on its own, so it needs no special case.
  assign rule_hit = rule_valid[idx]
                 && ((cur_protocol == 8'd0) || (cur_protocol == cap_protocol))
                 && ((cap_dstip & cur_mask) == (cur_dstip & cur_mask))
                 && (cur_port_lo <= cap_dstport)
                 && (cap_dstport <= cur_port_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hdr_fire) state_nxt = SCAN;
      SCAN:    if (rule_hit || last_idx) state_nxt = RESPOND;
      RESPOND: if (res_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      res_id       <= 1'b0;
      res_tag      <= '0;
      res_safe     <= 1'b0;
      cap_protocol <= 8'd0;
      cap_dstip    <= 32'd0;
      cap_dstport  <= 16'd0;
    end else begin
      if (hdr_fire) begin
        idx          <= '0;
        res_id       <= hdr_id;
        res_tag      <= hdr_tag;
        cap_protocol <= hdr_protocol;
        cap_dstip    <= hdr_dstip;
        cap_dstport  <= hdr_dstport;
      end else if (state == SCAN) begin
        if (rule_hit)      res_safe <= cur_safe;
        else if (last_idx) res_safe <= DEFAULT_SAFE;
        else               idx      <= idx + 1'b1;
      end
    end
  end

  // Only the valid bits need reset; payload is don't-care while its valid bit is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RULES; i++) rule_valid[i] <= 1'b0;
    end else if (wr_ok) begin
      rule_valid[rule_wr_idx] <= rule_wr_data[105];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) rule_data[rule_wr_idx] <= rule_wr_data[104:0];
  end

`ifdef FW_CLASSIFIER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_safe_cnt <= 32'd0;
      stat_drop_cnt <= 32'd0;
    end else if (stat_clr) begin
      stat_safe_cnt <= 32'd0;
      stat_drop_cnt <= 32'd0;
    end else if (res_fire) begin
      if (res_safe) begin
        if (stat_safe_cnt != 32'hFFFF_FFFF) stat_safe_cnt <= stat_safe_cnt + 32'd1;
      end else begin
        if (stat_drop_cnt != 32'hFFFF_FFFF) stat_drop_cnt <= stat_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fw_header_classifier.sv
// Scoreboard bench for fw_header_classifier: a rule-list reference model predicts each verdict
// and its latency; a separate monitor checks the result channel and applies backpressure.
module tb_fw_header_classifier;
  localparam int NR = 8;
  localparam int TW = 2;
  localparam int IW = $clog2(NR);
  localparam bit DS = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hdr_valid = 1'b0;
  logic          hdr_ready;
  logic          hdr_id = 1'b0;
  logic [TW-1:0] hdr_tag = '0;
  logic [7:0]    hdr_protocol = '0;
  logic [31:0]   hdr_srcip = '0;
  logic [31:0]   hdr_dstip = '0;
  logic [15:0]   hdr_srcport = '0;
  logic [15:0]   hdr_dstport = '0;
  logic          rule_wr_en = 1'b0;
  logic [IW-1:0] rule_wr_idx = '0;
  logic [105:0]  rule_wr_data = '0;
  logic          res_valid;
  logic          res_ready;
  logic          res_id;
  logic [TW-1:0] res_tag;
  logic          res_safe;
`ifdef FW_CLASSIFIER_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_safe_cnt;
  logic [31:0]   stat_drop_cnt;
`endif

  always #5 clk = ~clk;

  fw_header_classifier #(.NUM_RULES(NR), .TAG_W(TW), .DEFAULT_SAFE(DS)) dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_id(hdr_id), .hdr_tag(hdr_tag),
    .hdr_protocol(hdr_protocol), .hdr_srcip(hdr_srcip), .hdr_dstip(hdr_dstip),
    .hdr_srcport(hdr_srcport), .hdr_dstport(hdr_dstport),
    .rule_wr_en(rule_wr_en), .rule_wr_idx(rule_wr_idx), .rule_wr_data(rule_wr_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_tag(res_tag),
    .res_safe(res_safe)
`ifdef FW_CLASSIFIER_STATS_EN
    , .stat_clr(stat_clr), .stat_safe_cnt(stat_safe_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  typedef struct {
    bit        valid;
    bit        safe;
    bit [7:0]  proto;
    bit [31:0] ip;
    bit [31:0] mask;
    bit [15:0] lo;
    bit [15:0] hi;
  } rule_t;

  typedef struct {
    bit          id;
    bit [TW-1:0] tag;
    bit          safe;
    int          due;
  } exp_t;

  rule_t model [NR];
  exp_t  q [$];
  exp_t  cur;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    stall = 0;
  int    n_safe_hs = 0;
  int    n_drop_hs = 0;
  bit    mon_busy = 1'b0;
  bit    hs_pend = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected progress (cycle %0d)", nm, cyc);
  endtask

  function automatic rule_t mk_rule(input bit v, input bit s, input bit [7:0] p, input bit [31:0] ip,
                                    input bit [31:0] m, input bit [15:0] lo, input bit [15:0] hi);
    rule_t r;
    r.valid = v; r.safe = s; r.proto = p; r.ip = ip; r.mask = m; r.lo = lo; r.hi = hi;
    return r;
  endfunction

  // First matching rule in list order decides; no match falls to the default at the last index.
  function automatic void classify(input bit [7:0] p, input bit [31:0] ip, input bit [15:0] port,
                                   output bit safe, output int m);
    safe = DS;
    m = NR - 1;
    for (int i = 0; i < NR; i++) begin
      rule_t r;
      r = model[i];
      if (r.valid && (r.proto == 0 || r.proto == p) && ((ip & r.mask) == (r.ip & r.mask)) &&
          port >= r.lo && port <= r.hi) begin
        safe = r.safe;
        m = i;
        return;
      end
    end
  endfunction

  task automatic wr_rule(input int i, input rule_t r);
    rule_wr_idx  = IW'(i);
    rule_wr_data = {r.valid, r.safe, r.proto, r.ip, r.mask, r.lo, r.hi};
    rule_wr_en   = 1'b1;
    @(posedge clk); #1;
    rule_wr_en   = 1'b0;
    model[i]     = r;
  endtask

  task automatic send_hdr(input bit id, input bit [TW-1:0] tag, input bit [7:0] p,
                          input bit [31:0] ip, input bit [15:0] port);
    exp_t e;
    bit   s;
    int   m;
    int   t;
    hdr_id = id; hdr_tag = tag; hdr_protocol = p; hdr_dstip = ip; hdr_dstport = port;
    hdr_srcip = $urandom; hdr_srcport = 16'($urandom);
    hdr_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!hdr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!hdr_ready) begin
      fail_now("hdr_accept_timeout");
      hdr_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    classify(p, ip, port, s, m);
    e.id = id; e.tag = tag; e.safe = s; e.due = cyc + 1 + m + 1;
    q.push_back(e);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(q.size() == 0 && !mon_busy && hdr_ready) && t < 400) begin
      @(negedge clk); #2;
      t++;
    end
    if (t >= 400) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy = 1'b0; hs_pend = 1'b0; res_ready = 1'b0;
        continue;
      end
      if (hs_pend) begin
        chk("post_hs_res_valid", res_valid, 0);
        chk("post_hs_hdr_ready", hdr_ready, 1);
        hs_pend = 1'b0;
        mon_busy = 1'b0;
      end
      if (res_valid) begin
        if (!mon_busy) begin
          if (q.size() == 0) begin
            fail_now("unexpected_verdict");
            cur.id = res_id; cur.tag = res_tag; cur.safe = res_safe;
          end else begin
            cur = q.pop_front();
            chk("latency_cycle", 64'(cyc), 64'(cur.due));
          end
          mon_busy = 1'b1;
        end
        chk("res_id", res_id, cur.id);
        chk("res_tag", res_tag, cur.tag);
        chk("res_safe", res_safe, cur.safe);
        chk("hdr_ready_busy", hdr_ready, 0);
        if (stall > 0) begin
          res_ready = 1'b0;
          stall--;
        end else begin
          res_ready = ($urandom_range(0, 3) != 0);
        end
        if (res_ready) begin
          hs_pend = 1'b1;
          if (cur.safe) n_safe_hs++;
          else          n_drop_hs++;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rule_t r;
    for (int i = 0; i < NR; i++) model[i] = mk_rule(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_ready", hdr_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_safe", res_safe, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty table: default verdict after the full scan.
    send_hdr(1'b1, 2'd2, 8'd6, 32'h0A01_0203, 16'd80);
    drain();

    wr_rule(3, mk_rule(1, 1, 8'd6, 32'h0A00_0000, 32'hFF00_0000, 16'd80, 16'd80));
    send_hdr(1'b0, 2'd1, 8'd6, 32'h0A01_0203, 16'd80);
    send_hdr(1'b1, 2'd3, 8'd6, 32'h0A01_0203, 16'd81);
    drain();

    // Two overlapping wildcard rules: the lower index must decide.
    wr_rule(3, mk_rule(0, 0, 0, 0, 0, 0, 0));
    wr_rule(1, mk_rule(1, 0, 8'd0, 32'h0, 32'h0, 16'd0, 16'hFFFF));
    wr_rule(5, mk_rule(1, 1, 8'd0, 32'h0, 32'h0, 16'd0, 16'hFFFF));
    send_hdr(1'b0, 2'd0, 8'd17, 32'hC0A8_0001, 16'd53);
    drain();

    stall = 5;
    send_hdr(1'b1, 2'd1, 8'd6, 32'h0101_0101, 16'd443);
    send_hdr(1'b0, 2'd2, 8'd1, 32'h0202_0202, 16'd7);
    drain();

    // A write landing while its entry is being scanned must not affect that scan.
    wr_rule(1, mk_rule(0, 0, 0, 0, 0, 0, 0));
    wr_rule(5, mk_rule(0, 0, 0, 0, 0, 0, 0));
    send_hdr(1'b1, 2'd0, 8'd6, 32'h0A00_0001, 16'd22);
    wr_rule(0, mk_rule(1, 1, 8'd6, 32'h0A00_0000, 32'hFFFF_FF00, 16'd20, 16'd25));
    drain();
    send_hdr(1'b1, 2'd0, 8'd6, 32'h0A00_0001, 16'd22);
    drain();

    // Reset in the middle of a scan drops the header and empties the table.
    wr_rule(0, mk_rule(0, 0, 0, 0, 0, 0, 0));
    wr_rule(7, mk_rule(1, 1, 8'd0, 32'h0, 32'h0, 16'd0, 16'hFFFF));
    send_hdr(1'b0, 2'd3, 8'd6, 32'h0303_0303, 16'd1000);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midscan_rst_hdr_ready", hdr_ready, 1);
    chk("midscan_rst_res_valid", res_valid, 0);
    q.delete();
    for (int i = 0; i < NR; i++) model[i] = mk_rule(0, 0, 0, 0, 0, 0, 0);
    stall = 0;
    n_safe_hs = 0;
    n_drop_hs = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_hdr(1'b0, 2'd3, 8'd6, 32'h0303_0303, 16'd1000);
    drain();

    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        r.valid = ($urandom_range(0, 3) != 0);
        r.safe  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       r.proto = 8'd0;
          1:       r.proto = 8'd6;
          default: r.proto = 8'd17;
        endcase
        r.ip = {8'd10, 8'($urandom_range(0, 3)), 16'($urandom)};
        case ($urandom_range(0, 3))
          0:       r.mask = 32'h0;
          1:       r.mask = 32'hFF00_0000;
          2:       r.mask = 32'hFFFF_0000;
          default: r.mask = 32'hFFFF_FFFF;
        endcase
        r.lo = 16'($urandom_range(0, 100));
        r.hi = ($urandom_range(0, 4) == 0) ? r.lo - 16'd5 : r.lo + 16'($urandom_range(0, 40));
        wr_rule(int'($urandom_range(0, NR - 1)), r);
      end
      for (int h = 0; h < 5; h++) begin
        if ($urandom_range(0, 9) == 0) stall = int'($urandom_range(1, 4));
        send_hdr(1'($urandom), 2'($urandom), ($urandom_range(0, 1) != 0) ? 8'd6 : 8'd17,
                 {8'd10, 8'($urandom_range(0, 3)), 16'($urandom)}, 16'($urandom_range(0, 140)));
      end
      drain();
    end

`ifdef FW_CLASSIFIER_STATS_EN
    chk("stat_safe_cnt", stat_safe_cnt, 64'(n_safe_hs));
    chk("stat_drop_cnt", stat_drop_cnt, 64'(n_drop_hs));
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("stat_safe_clr", stat_safe_cnt, 0);
    chk("stat_drop_clr", stat_drop_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
